// File: rtl/flow_stream_tx_if.sv
// Valid/ready word stream from flow_stream_tx into the downstream pipeline.
// The master drives valid/data; the slave returns ready.
interface flow_stream_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/flow_stream_tx.sv
// Burst source: streams len words from a small write-loaded buffer onto a valid/ready link.
// Define FLOW_TX_LOOP_EN to allow back-to-back bursts with no bubble when start meets the final transfer.
module flow_stream_tx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  flow_stream_tx_if.master  tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LenMax = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne = (ADDR_W)'(1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   eff_len_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic              xfer;
  logic              last_word;
  logic              len_nz;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W:0]   len_clamped;
  logic [DATA_W-1:0] first_word;

  assign tx.valid = valid_q;
  assign tx.data  = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    mem_we      = wr_en && (state_q == StIdle);
    xfer        = valid_q && tx.ready;
    last_word   = (cnt_q + CntOne) == eff_len_q;
    len_nz      = (len != '0);
    ptr_inc     = ptr_q + PtrOne;
    len_clamped = (len > LenMax) ? LenMax : len;
    // A write landing on the same edge as start must be visible in the first word.
    first_word  = (mem_we && (wr_addr == start_addr)) ? wr_data : mem[start_addr];
  end

  // Buffer contents survive reset on purpose.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      eff_len_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len_nz) begin
              eff_len_q <= len_clamped;
              ptr_q     <= start_addr;
              cnt_q     <= '0;
              data_q    <= first_word;
              valid_q   <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= StSend;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end

        StSend: begin
          if (xfer) begin
            if (!last_word) begin
              ptr_q  <= ptr_inc;
              cnt_q  <= cnt_q + CntOne;
              data_q <= mem[ptr_inc];
            end else begin
`ifdef FLOW_TX_LOOP_EN
              if (start && len_nz) begin
                eff_len_q <= len_clamped;
                ptr_q     <= start_addr;
                cnt_q     <= '0;
                data_q    <= first_word;
                done_q    <= 1'b1;
              end else begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StDone;
              end
`else
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
`endif
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flow_stream_tx.sv
// Directed bench for flow_stream_tx: a queue-based burst model checked every cycle,
// plus literal word sequences for each scenario.
module tb_flow_stream_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] start_addr;
  logic [2:0] len;
  logic       ready;
  logic       busy;
  logic       done;

  flow_stream_tx_if #(.DATA_W(8)) tx_if ();
  assign tx_if.ready = ready;

  flow_stream_tx #(.DATA_W(8), .ADDR_W(2)) dut (
    .CLK        (clk),
    .RESET_n    (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .tx         (tx_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  bit         chk_en    = 1'b0;
  bit         m_active  = 1'b0;
  bit         m_in_done = 1'b0;
  bit         exp_done  = 1'b0;
  logic [7:0] shadow [4];
  logic [7:0] exp_q [$];
  logic [7:0] got   [$];
  logic [7:0] want  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected words of a burst: min(len,4) entries read from the shadow buffer, wrapping mod 4.
  function automatic void build(input logic [1:0] sa, input logic [2:0] l);
    int eff;
    eff = (int'(l) > 4) ? 4 : int'(l);
    exp_q.delete();
    for (int i = 0; i < eff; i++) exp_q.push_back(shadow[(int'(sa) + i) % 4]);
  endfunction

  // Each negedge: compare outputs against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit nxt_done;
      bit nxt_in_done;
      check("valid", {31'd0, tx_if.valid}, {31'd0, m_active});
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("done", {31'd0, done}, {31'd0, exp_done});
      if (m_active) check("data", {24'd0, tx_if.data}, {24'd0, exp_q[0]});
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      nxt_done    = 1'b0;
      nxt_in_done = 1'b0;
      if (!m_active && !m_in_done) begin
        if (wr_en) shadow[wr_addr] = wr_data;
        if (start) begin
          if (len != 3'd0) begin
            build(start_addr, len);
            m_active = 1'b1;
          end else begin
            nxt_done    = 1'b1;
            nxt_in_done = 1'b1;
          end
        end
      end else if (m_active && ready) begin
        got.push_back(tx_if.data);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
`ifdef FLOW_TX_LOOP_EN
          if (start && len != 3'd0) begin
            build(start_addr, len);
            nxt_done = 1'b1;
          end else begin
            m_active    = 1'b0;
            nxt_done    = 1'b1;
            nxt_in_done = 1'b1;
          end
`else
          m_active    = 1'b0;
          nxt_done    = 1'b1;
          nxt_in_done = 1'b1;
`endif
        end
      end
      m_in_done = nxt_in_done;
      exp_done  = nxt_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_burst(input logic [1:0] sa, input logic [2:0] l);
    start      = 1'b1;
    start_addr = sa;
    len        = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!m_active && !m_in_done) return;
      tick();
    end
    check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", tag, i), {24'd0, got[i]}, {24'd0, want[i]});
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    ready      = 1'b0;
    #3;
    check("rst_valid", {31'd0, tx_if.valid}, 32'd0);
    check("rst_data", {24'd0, tx_if.data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    tick();
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    wr(2'd0, 8'hA1);
    wr(2'd1, 8'hB2);
    wr(2'd2, 8'hC3);
    wr(2'd3, 8'hD4);

    // Full burst with ready held high.
    done_cnt = 0;
    ready    = 1'b1;
    start_burst(2'd0, 3'd4);
    wait_idle("t1");
    want = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    check_log("t1");
    check("t1_done_pulses", done_cnt, 32'd1);

    // Same burst under ready back-pressure.
    begin
      bit pat [7];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tick();
      done_cnt = 0;
      start_burst(2'd0, 3'd4);
      for (int i = 0; i < 7; i++) begin
        ready = pat[i];
        tick();
      end
      ready = 1'b1;
      wait_idle("t2");
      want = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      check_log("t2");
      check("t2_done_pulses", done_cnt, 32'd1);
    end

    // Wrap-around and length clamp.
    tick();
    start_burst(2'd3, 3'd3);
    wait_idle("t3a");
    want = '{8'hD4, 8'hA1, 8'hB2};
    check_log("t3_wrap");
    tick();
    start_burst(2'd3, 3'd7);
    wait_idle("t3b");
    want = '{8'hD4, 8'hA1, 8'hB2, 8'hC3};
    check_log("t3_clamp");

    // Write and start on the same edge: the burst sees the new word.
    tick();
    wr_en   = 1'b1;
    wr_addr = 2'd2;
    wr_data = 8'h5A;
    start_burst(2'd2, 3'd1);
    wr_en = 1'b0;
    wait_idle("t3c");
    want = '{8'h5A};
    check_log("t3_bypass");
    tick();
    wr(2'd2, 8'hC3);

    // Zero-length start.
    tick();
    done_cnt = 0;
    busy_cnt = 0;
    start_burst(2'd0, 3'd0);
    wait_idle("t4a");
    tick();
    want.delete();
    check_log("t4_len0");
    check("t4_done_pulses", done_cnt, 32'd1);
    check("t4_busy_le1", {31'd0, busy_cnt <= 1}, 32'd1);

    // Writes during SEND are dropped.
    ready = 1'b0;
    start_burst(2'd0, 3'd4);
    wr_en   = 1'b1;
    wr_addr = 2'd1;
    wr_data = 8'hFF;
    tick();
    tick();
    wr_en = 1'b0;
    ready = 1'b1;
    wait_idle("t4b");
    want = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    check_log("t4_send");
    tick();
    start_burst(2'd0, 3'd4);
    wait_idle("t4c");
    want = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    check_log("t4_unchanged");

    // Reset after two transfers.
    tick();
    done_cnt = 0;
    start_burst(2'd0, 3'd4);
    for (int i = 0; i < 20 && got.size() < 2; i++) tick();
    check("t5_two_xfers", got.size(), 32'd2);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t5_valid_async", {31'd0, tx_if.valid}, 32'd0);
    check("t5_busy_async", {31'd0, busy}, 32'd0);
    check("t5_data_async", {24'd0, tx_if.data}, 32'd0);
    want = '{8'hA1, 8'hB2};
    check_log("t5_pre");
    tick();
    tick();
    check("t5_no_done", {31'd0, done}, 32'd0);
    check("t5_done_cnt", done_cnt, 32'd0);
    rst_n     = 1'b1;
    m_active  = 1'b0;
    m_in_done = 1'b0;
    exp_done  = 1'b0;
    exp_q.delete();
    chk_en    = 1'b1;
    tick();
    start_burst(2'd0, 3'd4);
    wait_idle("t5");
    want = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    check_log("t5_post");

`ifdef FLOW_TX_LOOP_EN
    // Back-to-back bursts with start held high.
    tick();
    done_cnt = 0;
    start      = 1'b1;
    start_addr = 2'd0;
    len        = 3'd2;
    for (int i = 0; i < 7; i++) tick();
    start = 1'b0;
    wait_idle("t6");
    check("t6_min_words", {31'd0, got.size() >= 6}, 32'd1);
    check("t6_even_words", got.size() % 2, 32'd0);
    check("t6_done_pulses", done_cnt, got.size() / 2);
    for (int i = 0; i < 6 && i < got.size(); i++)
      check($sformatf("t6_w%0d", i), {24'd0, got[i]}, (i % 2 == 0) ? 32'hA1 : 32'hB2);
    got.delete();
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
